// File: rtl/mc_pkg.sv
// Shared constants and types for the multi-cycle MIPS-subset core:
// opcode/funct encodings, ALU operation codes and FSM state codes.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_SLL = 3'd5,
    ALU_LUI = 3'd6
  } aluOp_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for the multi-cycle core; wrap-around arithmetic,
// signed SLT, SLL shifts operand B, LUI places B[15:0] in the upper half.
module mc_alu
  import mc_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [4:0]  i_shamt,
  output logic [31:0] o_result,
  output logic        o_zero
);

  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_SLT: o_result = {31'b0, ($signed(i_a) < $signed(i_b))};
      ALU_SLL: o_result = i_b << i_shamt;
      ALU_LUI: o_result = {i_b[15:0], 16'h0000};
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == 32'h0);

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS-subset core: register file, decode and control FSM sharing
// one ready-handshaked memory port for fetch and load/store.
module mc_datapath
  import mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_3000,
  parameter bit          REG_INIT_ZERO = 1'b1,
  parameter bit          TRAP_ILLEGAL  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic [2:0]  state_o,
  output logic        trap
);

  state_t      r_state, w_stateNext;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_aluOut, r_mdr;
  logic        r_memReq, r_memWe;
  logic [31:0] r_memAddr, r_memWdata;
  logic [31:0] r_regs [32];

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [15:0] w_imm;
  logic [25:0] w_idx;
  logic [31:0] w_sext, w_zext, w_rsVal, w_rtVal;
  logic [31:0] w_branchTarget, w_jumpTarget, w_pcNext;
  logic        w_isRalu, w_isJr, w_isJ, w_isJal, w_isBeq;
  logic        w_isAddiu, w_isOri, w_isLui, w_isLw, w_isSw;
  logic        w_legal, w_accept;
  logic [2:0]  w_aluOp;
  logic [31:0] w_aluB, w_aluResult;
  logic        w_aluZero;
  logic        w_rfWe;
  logic [4:0]  w_rfWaddr;
  logic [31:0] w_rfWdata;

  assign w_op    = r_ir[31:26];
  assign w_rs    = r_ir[25:21];
  assign w_rt    = r_ir[20:16];
  assign w_rd    = r_ir[15:11];
  assign w_shamt = r_ir[10:6];
  assign w_funct = r_ir[5:0];
  assign w_imm   = r_ir[15:0];
  assign w_idx   = r_ir[25:0];
  assign w_sext  = {{16{w_imm[15]}}, w_imm};
  assign w_zext  = {16'h0000, w_imm};

  assign w_rsVal = (w_rs == 5'd0) ? 32'h0 : r_regs[w_rs];
  assign w_rtVal = (w_rt == 5'd0) ? 32'h0 : r_regs[w_rt];

  // r_pc already holds PC+4 once FETCH completes, so both targets build on it.
  assign w_branchTarget = r_pc + {w_sext[29:0], 2'b00};
  assign w_jumpTarget   = {r_pc[31:28], w_idx, 2'b00};
  assign w_accept       = r_memReq & mem_ready;

  always_comb begin
    w_isRalu  = 1'b0;
    w_isJr    = 1'b0;
    w_isJ     = 1'b0;
    w_isJal   = 1'b0;
    w_isBeq   = 1'b0;
    w_isAddiu = 1'b0;
    w_isOri   = 1'b0;
    w_isLui   = 1'b0;
    w_isLw    = 1'b0;
    w_isSw    = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLL: w_isRalu = 1'b1;
          FN_JR:   w_isJr = 1'b1;
          default: ;
        endcase
      end
      OP_J:     w_isJ     = 1'b1;
      OP_JAL:   w_isJal   = 1'b1;
      OP_BEQ:   w_isBeq   = 1'b1;
      OP_ADDIU: w_isAddiu = 1'b1;
      OP_ORI:   w_isOri   = 1'b1;
      OP_LUI:   w_isLui   = 1'b1;
      OP_LW:    w_isLw    = 1'b1;
      OP_SW:    w_isSw    = 1'b1;
      default:  ;
    endcase
  end

  assign w_legal = w_isRalu | w_isJr | w_isJ | w_isJal | w_isBeq | w_isAddiu
                 | w_isOri | w_isLui | w_isLw | w_isSw;

  always_comb begin
    w_aluOp = ALU_ADD;
    w_aluB  = w_sext;
    if (w_isRalu) begin
      w_aluB = r_b;
      case (w_funct)
        FN_SUBU: w_aluOp = ALU_SUB;
        FN_AND:  w_aluOp = ALU_AND;
        FN_OR:   w_aluOp = ALU_OR;
        FN_SLT:  w_aluOp = ALU_SLT;
        FN_SLL:  w_aluOp = ALU_SLL;
        default: w_aluOp = ALU_ADD;
      endcase
    end else if (w_isOri) begin
      w_aluOp = ALU_OR;
      w_aluB  = w_zext;
    end else if (w_isLui) begin
      w_aluOp = ALU_LUI;
      w_aluB  = w_zext;
    end else if (w_isBeq) begin
      w_aluOp = ALU_SUB;
      w_aluB  = r_b;
    end
  end

  mc_alu u_alu (
    .i_op     (w_aluOp),
    .i_a      (r_a),
    .i_b      (w_aluB),
    .i_shamt  (w_shamt),
    .o_result (w_aluResult),
    .o_zero   (w_aluZero)
  );

  always_comb begin
    w_stateNext = r_state;
    w_pcNext    = r_pc;
    case (r_state)
      S_FETCH: begin
        if (w_accept) begin
          w_stateNext = S_DECODE;
          w_pcNext    = r_pc + 32'd4;
        end
      end
      S_DECODE: begin
        if (w_isJ || w_isJal) begin
          w_pcNext    = w_jumpTarget;
          w_stateNext = S_FETCH;
        end else if (w_isJr) begin
          w_pcNext    = w_rsVal;
          w_stateNext = S_FETCH;
        end else if (!w_legal && TRAP_ILLEGAL) begin
          w_stateNext = S_TRAP;
        end else begin
          w_stateNext = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_isBeq) begin
          if (w_aluZero) w_pcNext = r_aluOut;
          w_stateNext = S_FETCH;
        end else if (w_isLw || w_isSw) begin
          w_stateNext = S_MEM;
        end else begin
          w_stateNext = S_WB;
        end
      end
      S_MEM: begin
        if (w_accept) w_stateNext = w_isSw ? S_FETCH : S_WB;
      end
      S_WB:    w_stateNext = S_FETCH;
      S_TRAP:  w_stateNext = S_TRAP;
      default: w_stateNext = S_FETCH;
    endcase
  end

  // Illegal instructions running as NOPs reach WB with no write selected.
  always_comb begin
    w_rfWe    = 1'b0;
    w_rfWaddr = 5'd0;
    w_rfWdata = 32'h0;
    if (r_state == S_DECODE && w_isJal) begin
      w_rfWe    = 1'b1;
      w_rfWaddr = 5'd31;
      w_rfWdata = r_pc;
    end else if (r_state == S_WB) begin
      if (w_isRalu) begin
        w_rfWe    = 1'b1;
        w_rfWaddr = w_rd;
        w_rfWdata = r_aluOut;
      end else if (w_isAddiu || w_isOri || w_isLui) begin
        w_rfWe    = 1'b1;
        w_rfWaddr = w_rt;
        w_rfWdata = r_aluOut;
      end else if (w_isLw) begin
        w_rfWe    = 1'b1;
        w_rfWaddr = w_rt;
        w_rfWdata = r_mdr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && REG_INIT_ZERO) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'h0;
    end else if (!reset && w_rfWe && w_rfWaddr != 5'd0) begin
      r_regs[w_rfWaddr] <= w_rfWdata;
    end
  end

  // Memory port is registered from the next state so it is glitch-free and
  // holds steady through wait states; the first fetch after reset idles once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_ir       <= 32'h0;
      r_a        <= 32'h0;
      r_b        <= 32'h0;
      r_aluOut   <= 32'h0;
      r_mdr      <= 32'h0;
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= 32'h0;
      r_memWdata <= 32'h0;
    end else begin
      r_state <= w_stateNext;
      r_pc    <= w_pcNext;
      if (r_state == S_FETCH && w_accept) r_ir <= mem_rdata;
      if (r_state == S_DECODE) begin
        r_a      <= w_rsVal;
        r_b      <= w_rtVal;
        r_aluOut <= w_branchTarget;
      end
      if (r_state == S_EXEC) r_aluOut <= w_aluResult;
      if (r_state == S_MEM && w_accept && w_isLw) r_mdr <= mem_rdata;
      r_memReq <= (w_stateNext == S_FETCH) || (w_stateNext == S_MEM);
      r_memWe  <= (w_stateNext == S_MEM) && w_isSw;
      if (w_stateNext == S_FETCH) begin
        r_memAddr <= {w_pcNext[31:2], 2'b00};
      end else if (w_stateNext == S_MEM) begin
        r_memAddr  <= {w_aluResult[31:2], 2'b00};
        r_memWdata <= r_b;
      end
    end
  end

  assign mem_req   = r_memReq;
  assign mem_we    = r_memWe;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign pc_o      = r_pc;
  assign instr_o   = r_ir;
  assign state_o   = r_state;
  assign trap      = (r_state == S_TRAP);

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: a wait-state memory model, reset, ALU/load/store,
// branch/jump fetch timing, and trap versus NOP handling of an illegal opcode.
module tb_mc_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o, instr_o;
  logic [2:0]  state_o;

  logic        m2Req, m2We, m2Trap;
  logic [31:0] m2Addr, m2Wdata, m2Rdata, m2Pc, m2Instr;
  logic [2:0]  m2State;

  logic [31:0] memArr [0:4095];
  int          dataWait = 0;
  int          codeWait = 0;
  bit          forceNoReady = 1'b1;
  int          waitCnt = 0;
  int          cycle = 0;
  int          stableCnt = 0;
  int          errors = 0;
  int          checks = 0;
  bit          m2StoreSeen = 1'b0;
  logic [31:0] fetchAddr[$];
  int          fetchCyc[$];
  logic [31:0] m2Fetch[$];
  int          m2Cyc[$];

  always #5 clk = ~clk;

  mc_datapath dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc_o(pc_o), .instr_o(instr_o),
    .state_o(state_o), .trap(trap)
  );

  mc_datapath #(.TRAP_ILLEGAL(1'b0)) dutNop (
    .clk(clk), .reset(reset), .mem_req(m2Req), .mem_we(m2We),
    .mem_addr(m2Addr), .mem_wdata(m2Wdata), .mem_rdata(m2Rdata),
    .mem_ready(1'b1), .pc_o(m2Pc), .instr_o(m2Instr),
    .state_o(m2State), .trap(m2Trap)
  );

  // Data addresses (below 0x1000) and code addresses get independent wait counts.
  always_comb
    mem_ready = !forceNoReady && mem_req &&
                (waitCnt >= ((mem_addr < 32'h1000) ? dataWait : codeWait));
  assign mem_rdata = memArr[mem_addr[13:2]];
  assign m2Rdata   = memArr[m2Addr[13:2]];

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (reset || !mem_req || mem_ready) waitCnt <= 0;
    else waitCnt <= waitCnt + 1;
    if (!reset && mem_req && mem_ready) begin
      if (mem_we) memArr[mem_addr[13:2]] <= mem_wdata;
      else if (mem_addr >= 32'h3000) begin
        fetchAddr.push_back(mem_addr);
        fetchCyc.push_back(cycle);
      end
    end
    if (!reset && m2Req && !m2We) begin
      m2Fetch.push_back(m2Addr);
      m2Cyc.push_back(cycle);
    end
    if (!reset && m2Req && m2We && m2Wdata != 32'hFFFF_FFFF) m2StoreSeen <= 1'b1;
  end

  always @(negedge clk)
    if (mem_req && mem_we && mem_addr == 32'h4 && mem_wdata == 32'h8000_FFFF)
      stableCnt++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst, input int nCycles);
    @(negedge clk);
    reset = rst;
    repeat (nCycles) @(posedge clk);
    #1;
  endtask

  task automatic waitFetches(input int n, input int budget);
    int spent = 0;
    while (fetchAddr.size() < n && spent < budget) begin
      @(posedge clk);
      #1;
      spent++;
    end
    if (fetchAddr.size() < n) checkOutput("fetchTimeout", fetchAddr.size(), n);
  endtask

  localparam int NF = 17;
  logic [31:0] expAddr  [NF] = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010,
                                 32'h3014, 32'h3018, 32'h301C, 32'h3020, 32'h3024,
                                 32'h3028, 32'h302C, 32'h3100, 32'h3104, 32'h3030,
                                 32'h3030, 32'h3030};
  int          expDelta [NF] = '{0, 4, 4, 4, 4, 6, 7, 6, 6, 3, 4, 6, 2, 6, 2, 3, 3};

  initial begin
    int reqCnt;
    reset = 1'b1;
    for (int i = 0; i < 4096; i++) memArr[i] = 32'h0;
    for (int i = 1; i <= 5; i++) memArr[i] = 32'hDEAD_BEEF;
    memArr[12'hC00] = 32'h3401_FFFF;  // ori   $1,$0,0xFFFF
    memArr[12'hC01] = 32'h3C02_8000;  // lui   $2,0x8000
    memArr[12'hC02] = 32'h0022_1821;  // addu  $3,$1,$2
    memArr[12'hC03] = 32'h0041_202A;  // slt   $4,$2,$1
    memArr[12'hC04] = 32'hAC03_0004;  // sw    $3,4($0)
    memArr[12'hC05] = 32'h8C05_0004;  // lw    $5,4($0)
    memArr[12'hC06] = 32'hAC04_0008;  // sw    $4,8($0)
    memArr[12'hC07] = 32'hAC05_000C;  // sw    $5,12($0)
    memArr[12'hC08] = 32'h1020_0004;  // beq   $1,$0,+4
    memArr[12'hC09] = 32'h2400_0005;  // addiu $0,$0,5
    memArr[12'hC0A] = 32'hAC00_0010;  // sw    $0,16($0)
    memArr[12'hC0B] = 32'h0C00_0C40;  // jal   0x3100
    memArr[12'hC0C] = 32'h1021_FFFF;  // beq   $1,$1,-1
    memArr[12'hC40] = 32'hAC1F_0014;  // sw    $31,20($0)
    memArr[12'hC41] = 32'h03E0_0008;  // jr    $31

    applyStimulus(1'b1, 3);
    checkOutput("rstPc", pc_o, 32'h3000);
    checkOutput("rstInstr", instr_o, 32'h0);
    checkOutput("rstReq", mem_req, 1'b0);
    checkOutput("rstWe", mem_we, 1'b0);
    checkOutput("rstAddr", mem_addr, 32'h0);
    checkOutput("rstWdata", mem_wdata, 32'h0);
    checkOutput("rstTrap", trap, 1'b0);
    checkOutput("rstState", state_o, 3'd0);

    applyStimulus(1'b0, 3);
    checkOutput("stallReq", mem_req, 1'b1);
    checkOutput("stallAddr", mem_addr, 32'h3000);
    checkOutput("stallState", state_o, 3'd0);
    applyStimulus(1'b1, 1);
    checkOutput("midRstReq", mem_req, 1'b0);
    checkOutput("midRstPc", pc_o, 32'h3000);
    checkOutput("midRstState", state_o, 3'd0);
    checkOutput("midRstInstr", instr_o, 32'h0);

    @(negedge clk);
    forceNoReady = 1'b0;
    dataWait = 2;
    fetchAddr.delete();
    fetchCyc.delete();
    stableCnt = 0;
    applyStimulus(1'b0, 1);
    waitFetches(NF, 2000);
    for (int i = 0; i < NF && i < fetchAddr.size(); i++) begin
      checkOutput($sformatf("fetchAddr%0d", i), fetchAddr[i], expAddr[i]);
      if (i > 0)
        checkOutput($sformatf("fetchCycles%0d", i), fetchCyc[i] - fetchCyc[i-1], expDelta[i]);
    end
    checkOutput("swAddu", memArr[1], 32'h8000_FFFF);
    checkOutput("swSlt", memArr[2], 32'h1);
    checkOutput("lwBack", memArr[3], 32'h8000_FFFF);
    checkOutput("zeroReg", memArr[4], 32'h0);
    checkOutput("jalLink", memArr[5], 32'h3030);
    checkOutput("swStable", stableCnt, 3);
    checkOutput("mainTrap", trap, 1'b0);

    memArr[12'hC00] = 32'hFC00_0000;  // opcode 0x3F
    memArr[12'hC01] = 32'h1000_FFFF;  // beq $0,$0,-1
    dataWait = 0;
    applyStimulus(1'b1, 2);
    m2Fetch.delete();
    m2Cyc.delete();
    m2StoreSeen = 1'b0;
    applyStimulus(1'b0, 6);
    checkOutput("trapFlag", trap, 1'b1);
    checkOutput("trapState", state_o, 3'd7);
    checkOutput("trapInstr", instr_o, 32'hFC00_0000);
    reqCnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) reqCnt++;
    end
    checkOutput("trapNoReq", reqCnt, 0);
    checkOutput("trapHeld", trap, 1'b1);
    checkOutput("trapPc", pc_o, 32'h3004);

    checkOutput("nopFetchCount", m2Fetch.size() >= 3, 1'b1);
    if (m2Fetch.size() >= 3) begin
      checkOutput("nopFetch0", m2Fetch[0], 32'h3000);
      checkOutput("nopFetch1", m2Fetch[1], 32'h3004);
      checkOutput("nopCycles", m2Cyc[1] - m2Cyc[0], 4);
      checkOutput("nopLoop", m2Fetch[2], 32'h3004);
    end
    checkOutput("nopTrap", m2Trap, 1'b0);
    checkOutput("nopNoStore", m2StoreSeen, 1'b0);

    applyStimulus(1'b1, 1);
    checkOutput("trapRstFlag", trap, 1'b0);
    checkOutput("trapRstState", state_o, 3'd0);
    checkOutput("trapRstReq", mem_req, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
